// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator car model: floor numbering,
// floor count and the door state encoding.
package elevator_pkg;

  localparam int NUM_FLOORS = 5;

  localparam logic [2:0] G  = 3'd0;
  localparam logic [2:0] F1 = 3'd1;
  localparam logic [2:0] F2 = 3'd2;
  localparam logic [2:0] F3 = 3'd3;
  localparam logic [2:0] F4 = 3'd4;

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } door_state_t;

  // One-hot level-sensor pattern for a floor number.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [2:0] f);
    return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
  endfunction

endpackage

// File: rtl/elevator_door_fsm.sv
// Door mechanism: CLOSED -> OPENING -> OPEN -> CLOSING strokes of DOOR_TICKS cycles.
// Optional macro DOOR_REOPEN_EN lets an open command reverse a closing stroke.
module elevator_door_fsm
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        open,
  input  logic        close,
  input  logic        open_ok,
  output logic        door_open,
  output logic        door_closed,
  output door_state_t state
);

  localparam logic [7:0] STROKE = 8'(DOOR_TICKS);

  door_state_t state_n;
  logic [7:0]  cnt, cnt_n;
  logic        reopen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLOSED;
      cnt         <= 8'd0;
      door_open   <= 1'b0;
      door_closed <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      door_open   <= (state_n == OPEN);
      door_closed <= (state_n == CLOSED);
    end
  end

  // cnt holds the number of cycles spent in the current stroke, starting at 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    reopen  = 1'b0;
    case (state)
      CLOSED: begin
        if (open && open_ok) begin
          state_n = OPENING;
          cnt_n   = 8'd1;
        end
      end
      OPENING: begin
        if (cnt == STROKE) state_n = OPEN;
        else               cnt_n   = cnt + 8'd1;
      end
      OPEN: begin
        if (close && !open) begin
          state_n = CLOSING;
          cnt_n   = 8'd1;
        end
      end
      CLOSING: begin
`ifdef DOOR_REOPEN_EN
        reopen = open;
`else
        reopen = 1'b0;
`endif
        // Reversing leaves exactly as many opening cycles as were spent closing.
        if (reopen) begin
          state_n = OPENING;
          cnt_n   = STROKE - cnt + 8'd1;
        end else if (cnt == STROKE) begin
          state_n = CLOSED;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = CLOSED;
    endcase
  end

endmodule

// File: rtl/elevator_car_model.sv
// Behavioural plant model of an elevator car: travel between G..F4, level sensors,
// door sub-module and a sticky interlock fault. Door reopen is enabled by DOOR_REOPEN_EN.
module elevator_car_model
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       open,
  input  logic       close,
  output logic [4:0] floor_at,
  output logic [2:0] floor_num,
  output logic       moving,
  output logic       door_open,
  output logic       door_closed,
  output logic       fault
);

  localparam logic [7:0] FT_LAST = 8'(FLOOR_TICKS - 1);

  door_state_t door_state;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  floor_n;
  logic        level, shut, up_ok, dn_ok, open_ok, fault_n;

  elevator_door_fsm #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clk        (clk),
    .rst        (rst),
    .open       (open),
    .close      (close),
    .open_ok    (open_ok),
    .door_open  (door_open),
    .door_closed(door_closed),
    .state      (door_state)
  );

  // Position is floor_num*FLOOR_TICKS + cnt, so a reversal mid-floor simply
  // walks the offset back toward floor_num; no separate direction state is needed.
  always_comb begin
    level   = (cnt == 8'd0);
    shut    = (door_state == CLOSED);
    up_ok   = up && !down && shut && !fault && !(level && floor_num == F4);
    dn_ok   = down && !up && shut && !fault && !(level && floor_num == G);
    cnt_n   = cnt;
    floor_n = floor_num;
    if (up_ok) begin
      if (cnt == FT_LAST) begin
        cnt_n   = 8'd0;
        floor_n = floor_num + 3'd1;
      end else begin
        cnt_n = cnt + 8'd1;
      end
    end else if (dn_ok) begin
      if (level) begin
        cnt_n   = FT_LAST;
        floor_n = floor_num - 3'd1;
      end else begin
        cnt_n = cnt - 8'd1;
      end
    end
    fault_n = fault || (up && down) || ((up || down) && !shut);
    // The door may only start opening on a car that is parked and staying parked.
    open_ok = level && !moving && !up_ok && !dn_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 8'd0;
      floor_num <= G;
      floor_at  <= 5'b00001;
      moving    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      floor_num <= floor_n;
      floor_at  <= (cnt_n == 8'd0) ? floor_onehot(floor_n) : 5'b00000;
      moving    <= up_ok || dn_ok;
      fault     <= fault_n;
    end
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// Bench for elevator_car_model: directed scenarios plus random commands, checked
// against a position/door-travel reference model. Honours DOOR_REOPEN_EN.
module tb_elevator_car_model;

  localparam int FT = 8;
  localparam int DT = 4;
  localparam int NF = 5;
`ifdef DOOR_REOPEN_EN
  localparam bit REOPEN = 1'b1;
`else
  localparam bit REOPEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, up, down, open, close;
  logic [4:0] floor_at;
  logic [2:0] floor_num;
  logic       moving, door_open, door_closed, fault;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  // Reference model: car position in ticks above G, door travel 0 (shut) .. DT (open).
  int m_pos, m_dpos, m_ddir;
  bit m_moving, m_fault;

  always #5 clk = ~clk;

  elevator_car_model #(
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .open       (open),
    .close      (close),
    .floor_at   (floor_at),
    .floor_num  (floor_num),
    .moving     (moving),
    .door_open  (door_open),
    .door_closed(door_closed),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit m_shut();
    return (m_dpos == 0) && (m_ddir == 0);
  endfunction

  task automatic model_step(input bit r, input bit u, input bit d, input bit o, input bit c);
    bit shut, level, up_ok, dn_ok, open_ok;
    logic [4:0] fa;
    if (r) begin
      m_pos = 0; m_dpos = 0; m_ddir = 0; m_moving = 0; m_fault = 0;
    end else begin
      shut    = m_shut();
      level   = (m_pos % FT) == 0;
      up_ok   = u && !d && shut && !m_fault && (m_pos < (NF - 1) * FT);
      dn_ok   = d && !u && shut && !m_fault && (m_pos > 0);
      open_ok = level && !m_moving && !up_ok && !dn_ok;
      if (m_ddir == 0) begin
        if (m_dpos == 0 && o && open_ok) begin
          m_ddir = 1; m_dpos = 1;
        end else if (m_dpos == DT && c && !o) begin
          m_ddir = -1; m_dpos = DT - 1;
        end
      end else if (REOPEN && m_ddir < 0 && o) begin
        m_ddir = 1; m_dpos = m_dpos + 1;
      end else if ((m_ddir > 0 && m_dpos == DT) || (m_ddir < 0 && m_dpos == 0)) begin
        m_ddir = 0;
      end else begin
        m_dpos = m_dpos + m_ddir;
      end
      m_fault  = m_fault || (u && d) || ((u || d) && !shut);
      if (up_ok)      m_pos = m_pos + 1;
      else if (dn_ok) m_pos = m_pos - 1;
      m_moving = up_ok || dn_ok;
    end
    fa = ((m_pos % FT) == 0) ? 5'(1 << (m_pos / FT)) : 5'd0;
    exp_q.push_back({fa, 3'(m_pos / FT), m_moving,
                     (m_dpos == DT && m_ddir == 0), m_shut(), m_fault});
  endtask

  task automatic cycle(input bit r, input bit u, input bit d, input bit o, input bit c);
    logic [11:0] e;
    rst = r; up = u; down = d; open = o; close = c;
    @(posedge clk);
    model_step(r, u, d, o, c);
    #1;
    e = exp_q.pop_front();
    check("floor_at",    8'(floor_at),    8'(e[11:7]));
    check("floor_num",   8'(floor_num),   8'(e[6:4]));
    check("moving",      8'(moving),      8'(e[3]));
    check("door_open",   8'(door_open),   8'(e[2]));
    check("door_closed", 8'(door_closed), 8'(e[1]));
    check("fault",       8'(fault),       8'(e[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int r;
    bit rr, u, d, o, c;

    // Reset state
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst floor_at", 8'(floor_at), 8'h01);
    check("rst floor_num", 8'(floor_num), 8'h00);
    check("rst door_closed", 8'(door_closed), 8'h01);
    check("rst fault", 8'(fault), 8'h00);

    // One floor up takes FLOOR_TICKS cycles of continuous motion
    for (int i = 0; i < FT; i++) begin
      cycle(0, 1, 0, 0, 0);
      check("climb moving", 8'(moving), 8'h01);
    end
    check("climb floor_num", 8'(floor_num), 8'h01);
    check("climb floor_at", 8'(floor_at), 8'h02);
    for (int i = 0; i < FT; i++) cycle(0, 0, 1, 0, 0);

    // Stop between floors, then return
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    idle(1);
    check("midway floor_at", 8'(floor_at), 8'h00);
    check("midway floor_num", 8'(floor_num), 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
    check("back floor_at", 8'(floor_at), 8'h01);

    // Door stroke at F2
    for (int i = 0; i < 2 * FT; i++) cycle(0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 0, 0, 1, 0);
    check("opening door_closed", 8'(door_closed), 8'h00);
    idle(4);
    check("opened door_open", 8'(door_open), 8'h01);
    cycle(0, 0, 0, 0, 1);
    idle(4);
    check("shut door_closed", 8'(door_closed), 8'h01);

    // Motion with door open faults and stays blocked until reset
    cycle(0, 0, 0, 1, 0);
    idle(4);
    cycle(0, 1, 0, 0, 0);
    check("door interlock fault", 8'(fault), 8'h01);
    check("door interlock floor", 8'(floor_num), 8'h02);
    cycle(0, 0, 0, 0, 1);
    idle(4);
    check("fault door still works", 8'(door_closed), 8'h01);
    cycle(0, 1, 0, 0, 0);
    check("fault blocks motion", 8'(moving), 8'h00);
    cycle(1, 0, 0, 0, 0);
    check("rst clears fault", 8'(fault), 8'h00);

    // Conflicting commands and top-floor saturation
    cycle(0, 1, 1, 0, 0);
    check("up+down fault", 8'(fault), 8'h01);
    check("up+down no motion", 8'(moving), 8'h00);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < (NF - 1) * FT; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("F4 saturate moving", 8'(moving), 8'h00);
    check("F4 saturate fault", 8'(fault), 8'h00);
    check("F4 floor_at", 8'(floor_at), 8'h10);

    // Open request two cycles into a closing stroke
    cycle(0, 0, 0, 1, 0);
    idle(4);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    for (int j = 0; j < 8; j++) begin
      cycle(0, 0, 0, 1, 0);
      if (j == 2) begin
        if (REOPEN) check("reopen door_open", 8'(door_open), 8'h01);
        else        check("close first door_closed", 8'(door_closed), 8'h01);
      end
    end
    check("reopen final door_open", 8'(door_open), 8'h01);

    // Random commands, biased toward legal operation
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 99);
      rr = (m_fault && $urandom_range(0, 7) == 0) || ($urandom_range(0, 399) == 0);
      u = 0; d = 0; o = 0; c = 0;
      if (m_shut()) begin
        if (r < 40)      u = 1;
        else if (r < 75) d = 1;
        else if (r < 77) begin u = 1; d = 1; end
        else if (r < 85) o = 1;
        else if (r < 88) begin o = 1; u = ($urandom_range(0, 1) == 1); end
      end else begin
        if (r < 20)      c = 1;
        else if (r < 32) o = 1;
        else if (r < 35) u = 1;
        else if (r < 38) begin o = 1; c = 1; end
      end
      cycle(rr, u, d, o, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
